intr_prio_arbiter: RTL and testbench

//  Sequential, parametrised successor to the 9-channel, 3-bus combinational priority interrupt decoder.
//  Per-channel requests on three priority buses (A > B > C) are edge-latched into pending registers and

---
 rtl/intr_prio_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_intr_prio_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_prio_arbiter.sv
// Priority interrupt arbiter: edge-latched requests on three priority buses,
// masked per channel, one grant at a time through a valid/ack handshake with timeout.
module intr_prio_arbiter #(
    parameter int NCH     = 9,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 8,
    localparam int CW     = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic [NCH-1:0] chan_en,
    input  logic          irq_ack,
    input  logic          err_clr,
    output logic          irq_valid,
    output logic [1:0]    irq_bus,
    output logic [CW-1:0] irq_chan,
    output logic          ovf_err,
    output logic          timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  req_a_q, req_b_q, req_c_q;
    logic [NCH-1:0]  pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_c_q, pend_c_d;
    logic            irq_valid_q, irq_valid_d;
    logic [1:0]      irq_bus_q, irq_bus_d;
    logic [CW-1:0]   irq_chan_q, irq_chan_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
    logic            ovf_err_q, ovf_err_d;
    logic            timeout_err_q, timeout_err_d;

    logic [NCH-1:0]  edge_a_s, edge_b_s, edge_c_s;
    logic [NCH-1:0]  elig_a_s, elig_b_s, elig_c_s;
    logic [NCH-1:0]  clr_a_s, clr_b_s, clr_c_s;
    logic [NCH-1:0]  ack_mask_s;
    logic [CW-1:0]   start_s;
    logic            ovf_set_s, tmo_set_s;

    // First set bit at or after start, scanning upward and wrapping modulo NCH.
    function automatic logic [CW-1:0] pick_chan(input logic [NCH-1:0] vec,
                                                input logic [CW-1:0]  start);
        logic [CW-1:0] sel;
        logic          hit;
        int            idx;
        sel = {CW{1'b0}};
        hit = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(start) + k;
            idx = (idx >= NCH) ? (idx - NCH) : idx;
            if (!hit && vec[idx]) begin
                hit = 1'b1;
                sel = CW'(idx);
            end else begin
                hit = hit;
            end
        end
        return sel;
    endfunction

    function automatic logic [NCH-1:0] chan_mask(input logic [CW-1:0] ch);
        logic [NCH-1:0] m;
        m = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            m[i] = (CW'(i) == ch);
        end
        return m;
    endfunction

    // Arbitration, handshake FSM, pending bookkeeping and sticky error flags.
    always_comb begin
        edge_a_s      = req_a & ~req_a_q;
        edge_b_s      = req_b & ~req_b_q;
        edge_c_s      = req_c & ~req_c_q;
        elig_a_s      = pend_a_q & chan_en;
        elig_b_s      = pend_b_q & chan_en;
        elig_c_s      = pend_c_q & chan_en;
        start_s       = (RR_MODE != 0) ? rr_ptr_q : {CW{1'b0}};
        ack_mask_s    = chan_mask(irq_chan_q);
        clr_a_s       = {NCH{1'b0}};
        clr_b_s       = {NCH{1'b0}};
        clr_c_s       = {NCH{1'b0}};
        tmo_set_s     = 1'b0;
        state_d       = state_q;
        irq_valid_d   = irq_valid_q;
        irq_bus_d     = irq_bus_q;
        irq_chan_d    = irq_chan_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if ((|elig_a_s) || (|elig_b_s) || (|elig_c_s)) begin
                    state_d     = ST_GRANT;
                    irq_valid_d = 1'b1;
                    tmo_cnt_d   = 8'd0;
                    if (|elig_a_s) begin
                        irq_bus_d  = 2'd1;
                        irq_chan_d = pick_chan(elig_a_s, start_s);
                    end else if (|elig_b_s) begin
                        irq_bus_d  = 2'd2;
                        irq_chan_d = pick_chan(elig_b_s, start_s);
                    end else begin
                        irq_bus_d  = 2'd3;
                        irq_chan_d = pick_chan(elig_c_s, start_s);
                    end
                end else begin
                    irq_valid_d = 1'b0;
                    irq_bus_d   = 2'd0;
                end
            end
            ST_GRANT: begin
                if (irq_ack) begin
                    clr_a_s     = (irq_bus_q == 2'd1) ? ack_mask_s : {NCH{1'b0}};
                    clr_b_s     = (irq_bus_q == 2'd2) ? ack_mask_s : {NCH{1'b0}};
                    clr_c_s     = (irq_bus_q == 2'd3) ? ack_mask_s : {NCH{1'b0}};
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                    irq_bus_d   = 2'd0;
                    irq_chan_d  = {CW{1'b0}};
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (irq_chan_q == CW'(NCH - 1)) ? {CW{1'b0}}
                                                                 : irq_chan_q + CW'(1);
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    // Abandoned grant keeps its pending bit so it is re-arbitrated.
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                    irq_bus_d   = 2'd0;
                    irq_chan_d  = {CW{1'b0}};
                    tmo_set_s   = 1'b1;
                end else begin
                    tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                irq_valid_d = 1'b0;
                irq_bus_d   = 2'd0;
                irq_chan_d  = {CW{1'b0}};
            end
        endcase

        // A new edge beats a same-cycle ack clear and is then not an overflow.
        pend_a_d  = (pend_a_q & ~clr_a_s) | edge_a_s;
        pend_b_d  = (pend_b_q & ~clr_b_s) | edge_b_s;
        pend_c_d  = (pend_c_q & ~clr_c_s) | edge_c_s;
        ovf_set_s = (|(edge_a_s & pend_a_q & ~clr_a_s)) ||
                    (|(edge_b_s & pend_b_q & ~clr_b_s)) ||
                    (|(edge_c_s & pend_c_q & ~clr_c_s));

        if (ovf_set_s) begin
            ovf_err_d = 1'b1;
        end else if (err_clr) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q;
        end

        if (tmo_set_s) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State, pending, edge history and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_a_q       <= {NCH{1'b0}};
            req_b_q       <= {NCH{1'b0}};
            req_c_q       <= {NCH{1'b0}};
            pend_a_q      <= {NCH{1'b0}};
            pend_b_q      <= {NCH{1'b0}};
            pend_c_q      <= {NCH{1'b0}};
            irq_valid_q   <= 1'b0;
            irq_bus_q     <= 2'd0;
            irq_chan_q    <= {CW{1'b0}};
            rr_ptr_q      <= {CW{1'b0}};
            tmo_cnt_q     <= 8'd0;
            ovf_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_a_q       <= req_a;
            req_b_q       <= req_b;
            req_c_q       <= req_c;
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
            pend_c_q      <= pend_c_d;
            irq_valid_q   <= irq_valid_d;
            irq_bus_q     <= irq_bus_d;
            irq_chan_q    <= irq_chan_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            ovf_err_q     <= ovf_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign irq_valid   = irq_valid_q;
    assign irq_bus     = irq_bus_q;
    assign irq_chan    = irq_chan_q;
    assign ovf_err     = ovf_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_intr_prio_arbiter.sv
// Bench for intr_prio_arbiter: fixed-priority and round-robin instances share stimulus,
// a reference model queues expected grants and a monitor compares them as they appear.
module tb_intr_prio_arbiter;
    localparam int NCH = 9;
    localparam int CW  = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] req_a, req_b, req_c, chan_en;
    logic           irq_ack, err_clr;
    logic           dv    [2];
    logic [1:0]     dbus  [2];
    logic [CW-1:0]  dchan [2];
    logic           dovf  [2];
    logic           dterr [2];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int bus;
        int chan;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    bit m_pend [2][3][NCH];
    bit m_prev [2][3][NCH];
    bit m_gr   [2];
    int m_gb   [2];
    int m_gc   [2];
    int m_cnt  [2];
    int m_rr   [2];
    bit m_ovf  [2];
    bit m_terr [2];
    bit lastv  [2];

    always #5 clk = ~clk;

    intr_prio_arbiter #(.NCH(NCH), .RR_MODE(0), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .chan_en(chan_en), .irq_ack(irq_ack), .err_clr(err_clr),
        .irq_valid(dv[0]), .irq_bus(dbus[0]), .irq_chan(dchan[0]),
        .ovf_err(dovf[0]), .timeout_err(dterr[0]));

    intr_prio_arbiter #(.NCH(NCH), .RR_MODE(1), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .chan_en(chan_en), .irq_ack(irq_ack), .err_clr(err_clr),
        .irq_valid(dv[1]), .irq_bus(dbus[1]), .irq_chan(dchan[1]),
        .ovf_err(dovf[1]), .timeout_err(dterr[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit req_bit(input int b, input int i);
        case (b)
            0:       return req_a[i];
            1:       return req_b[i];
            default: return req_c[i];
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 3; b++)
                for (int i = 0; i < NCH; i++) begin
                    m_pend[m][b][i] = 1'b0;
                    m_prev[m][b][i] = 1'b0;
                end
            m_gr[m] = 1'b0; m_gb[m] = 0; m_gc[m] = 0; m_cnt[m] = 0;
            m_rr[m] = 0; m_ovf[m] = 1'b0; m_terr[m] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock of the reference behaviour for instance m (m==1 is round-robin).
    task automatic model_step(input int m);
        bit   op  [3][NCH];
        bit   clr [3][NCH];
        bit   found, ov_set, tm_set, e;
        int   start, idx, sb, sc;
        exp_t x;
        found = 1'b0; ov_set = 1'b0; tm_set = 1'b0; sb = 0; sc = 0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < NCH; i++) begin
                op[b][i]  = m_pend[m][b][i];
                clr[b][i] = 1'b0;
            end
        if (m_gr[m]) begin
            if (irq_ack) begin
                clr[m_gb[m] - 1][m_gc[m]] = 1'b1;
                m_gr[m] = 1'b0;
                if (m == 1) m_rr[m] = (m_gc[m] + 1) % NCH;
            end else if (m_cnt[m] == TMO - 1) begin
                m_gr[m] = 1'b0;
                tm_set  = 1'b1;
            end else if (m_cnt[m] < 255) begin
                m_cnt[m]++;
            end
        end else begin
            start = (m == 1) ? m_rr[m] : 0;
            for (int b = 0; b < 3; b++)
                for (int k = 0; k < NCH; k++) begin
                    idx = (start + k) % NCH;
                    if (!found && op[b][idx] && chan_en[idx]) begin
                        found = 1'b1; sb = b + 1; sc = idx;
                    end
                end
            if (found) begin
                m_gr[m] = 1'b1; m_gb[m] = sb; m_gc[m] = sc; m_cnt[m] = 0;
                x.bus = sb; x.chan = sc;
                if (m == 0) q0.push_back(x); else q1.push_back(x);
            end
        end
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < NCH; i++) begin
                e = req_bit(b, i) && !m_prev[m][b][i];
                if (e) begin
                    if (op[b][i] && !clr[b][i]) ov_set = 1'b1;
                    m_pend[m][b][i] = 1'b1;
                end else if (clr[b][i]) begin
                    m_pend[m][b][i] = 1'b0;
                end
                m_prev[m][b][i] = req_bit(b, i);
            end
        m_ovf[m]  = ov_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf[m]);
        m_terr[m] = tm_set ? 1'b1 : (err_clr ? 1'b0 : m_terr[m]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Monitor: pops an expected grant on each new DUT grant, tracks flags every cycle.
    always @(negedge clk) begin
        exp_t e;
        int   qs;
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                if (dv[m] && !lastv[m]) begin
                    qs = (m == 0) ? q0.size() : q1.size();
                    if (qs == 0) chk($sformatf("dut%0d_sb_unexpected_grant", m), qs, 1);
                    else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("dut%0d_sb_bus", m), int'(dbus[m]), e.bus);
                        chk($sformatf("dut%0d_sb_chan", m), int'(dchan[m]), e.chan);
                    end
                end
                chk($sformatf("dut%0d_valid", m), int'(dv[m]), int'(m_gr[m]));
                chk($sformatf("dut%0d_bus", m), int'(dbus[m]), m_gr[m] ? m_gb[m] : 0);
                if (m_gr[m]) chk($sformatf("dut%0d_chan", m), int'(dchan[m]), m_gc[m]);
                chk($sformatf("dut%0d_ovf_err", m), int'(dovf[m]), int'(m_ovf[m]));
                chk($sformatf("dut%0d_timeout_err", m), int'(dterr[m]), int'(m_terr[m]));
                lastv[m] = dv[m];
            end
        end else begin
            lastv[0] = 1'b0;
            lastv[1] = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        irq_ack = 1'b0; err_clr = 1'b0; chan_en = 9'h1FF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int m, input int budget);
        int n;
        n = 0;
        while (!dv[m] && n < budget) begin
            cyc();
            n++;
        end
        if (!dv[m]) chk($sformatf("dut%0d_wait_valid", m), int'(dv[m]), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        int order [4];
        int cnt;
        order = '{0, 2, 8, 0};
        rst_n = 1'b1; req_a = '0; req_b = '0; req_c = '0;
        chan_en = 9'h1FF; irq_ack = 1'b0; err_clr = 1'b0;
        #2;
        do_reset();
        chk("reset_valid", int'(dv[0]), 0);
        chk("reset_bus", int'(dbus[0]), 0);
        chk("reset_chan", int'(dchan[0]), 0);
        chk("reset_errs", int'(dovf[0]) + int'(dterr[0]), 0);

        // T1: single bus-C request, latency and ack.
        req_c[3] = 1'b1; cyc();
        chk("t1_no_valid_at_t1", int'(dv[0]), 0);
        cyc();
        chk("t1_valid", int'(dv[0]), 1);
        chk("t1_bus", int'(dbus[0]), 3);
        chk("t1_chan", int'(dchan[0]), 3);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t1_ack_valid", int'(dv[0]), 0);
        chk("t1_ack_bus", int'(dbus[0]), 0);
        req_c[3] = 1'b0;
        repeat (3) cyc();
        chk("t1_no_regrant", int'(dv[0]), 0);

        // T2: bus A beats bus B; one idle cycle between grants.
        req_b[7] = 1'b1; req_a[5] = 1'b1; cyc(); cyc();
        chk("t2_first_bus", int'(dbus[0]), 1);
        chk("t2_first_chan", int'(dchan[0]), 5);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t2_idle_gap", int'(dv[0]), 0);
        cyc();
        chk("t2_second_valid", int'(dv[0]), 1);
        chk("t2_second_bus", int'(dbus[0]), 2);
        chk("t2_second_chan", int'(dchan[0]), 7);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        req_a = '0; req_b = '0; cyc();

        // T3: round-robin order on the RR instance.
        do_reset();
        req_a = 9'h105;
        for (int k = 0; k < 4; k++) begin
            wait_valid(1, 10);
            chk($sformatf("t3_rr_chan_%0d", k), int'(dchan[1]), order[k]);
            chk($sformatf("t3_rr_bus_%0d", k), int'(dbus[1]), 1);
            irq_ack = 1'b1; req_a[order[k]] = 1'b0; cyc();
            irq_ack = 1'b0; req_a[order[k]] = 1'b1;
        end
        req_a = '0;

        // T4: timeout after TMO grant cycles, regrant, err_clr.
        do_reset();
        req_a[1] = 1'b1; cyc(); cyc();
        chk("t4_valid", int'(dv[0]), 1);
        cnt = 0;
        while (dv[0] && cnt < 20) begin
            cnt++;
            cyc();
        end
        chk("t4_grant_cycles", cnt, TMO);
        chk("t4_timeout_err", int'(dterr[0]), 1);
        cyc();
        chk("t4_regrant_valid", int'(dv[0]), 1);
        chk("t4_regrant_chan", int'(dchan[0]), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("t4_err_clr", int'(dterr[0]), 0);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0; req_a = '0;

        // T5: overflow while masked, then unmask.
        do_reset();
        chan_en = 9'h1EF;
        req_a[4] = 1'b1; cyc(); req_a[4] = 1'b0; cyc(); req_a[4] = 1'b1; cyc(); cyc();
        chk("t5_ovf_err", int'(dovf[0]), 1);
        chk("t5_no_grant", int'(dv[0]), 0);
        chan_en = 9'h1FF; cyc();
        chk("t5_grant_bus", int'(dbus[0]), 1);
        chk("t5_grant_chan", int'(dchan[0]), 4);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0; req_a = '0;

        // T6: asynchronous reset in the middle of a grant.
        do_reset();
        req_a[2] = 1'b1; cyc(); cyc();
        chk("t6_valid_before", int'(dv[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid0", int'(dv[0]), 0);
        chk("t6_async_valid1", int'(dv[1]), 0);
        chk("t6_async_bus", int'(dbus[0]), 0);
        chk("t6_async_chan", int'(dchan[0]), 0);
        req_a = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            cyc();
            if (dv[0] || dv[1]) cnt++;
        end
        chk("t6_no_grant_after", cnt, 0);

        // Randomized traffic checked by the scoreboard.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(0, 15) == 0) req_b[i] = ~req_b[i];
                if ($urandom_range(0, 15) == 0) req_c[i] = ~req_c[i];
            end
            if ($urandom_range(0, 31) == 0) chan_en = NCH'($urandom | $urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 24) == 0);
            cyc();
        end
        req_a = '0; req_b = '0; req_c = '0; chan_en = 9'h1FF;
        err_clr = 1'b0; irq_ack = 1'b1;
        repeat (80) cyc();
        irq_ack = 1'b0;
        repeat (3) cyc();
        chk("drain_valid0", int'(dv[0]), 0);
        chk("drain_q0_empty", q0.size(), 0);
        chk("drain_q1_empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
